// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised MIPS register file, 2 registered read ports, 1 write port, bulk clear.
// Optional write-first forwarding on read ports: define REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int TAP0_IDX = 2,
  parameter int TAP1_IDX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [DATA_W-1:0] tap_0,
  output logic [DATA_W-1:0] tap_1
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] TAP0_A = ADDR_W'(TAP0_IDX);
  localparam logic [ADDR_W-1:0] TAP1_A = ADDR_W'(TAP1_IDX);
  localparam logic [ADDR_W-1:0] LAST_A = {ADDR_W{1'b1}};

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_1_q, rd_data_2_q;
  logic [DATA_W-1:0] rd_data_1_d, rd_data_2_d;
  logic              rd_valid_q;
  logic              idle, wr_ok;

  assign idle  = (state_q == IDLE);
  // Writes to the hardwired zero register never reach the array.
  assign wr_ok = idle && wr_en && !(ZERO_REG != 0 && wr_addr == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_A) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data_1_d = (ZERO_REG != 0 && rd_addr_1 == '0) ? '0 : mem_q[rd_addr_1];
    rd_data_2_d = (ZERO_REG != 0 && rd_addr_2 == '0) ? '0 : mem_q[rd_addr_2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && wr_addr == rd_addr_1) rd_data_1_d = wr_data;
    if (wr_ok && wr_addr == rd_addr_2) rd_data_2_d = wr_data;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wr_ok) mem_q[wr_addr] <= wr_data;
      else if (state_q == CLEAR) mem_q[cnt_q] <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_1_q <= '0;
      rd_data_2_q <= '0;
      rd_valid_q  <= 1'b0;
    end else if (rd_en && idle) begin
      rd_data_1_q <= rd_data_1_d;
      rd_data_2_q <= rd_data_2_d;
      rd_valid_q  <= 1'b1;
    end else begin
      rd_valid_q  <= 1'b0;
    end
  end

  assign rd_data_1 = rd_data_1_q;
  assign rd_data_2 = rd_data_2_q;
  assign rd_valid  = rd_valid_q;
  assign clr_busy  = (state_q == CLEAR);
  assign tap_0     = (ZERO_REG != 0 && TAP0_A == '0) ? '0 : mem_q[TAP0_A];
  assign tap_1     = (ZERO_REG != 0 && TAP1_A == '0) ? '0 : mem_q[TAP1_A];
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp: vector table, corner sequences, random vs model.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0, clr_req = 1'b0;
  logic [4:0]  rd_addr_1 = '0, rd_addr_2 = '0, wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data_1, rd_data_2, tap_0, tap_1;
  logic        rd_valid, clr_busy;

  int n_pass = 0;
  int n_tot  = 0;

  logic [31:0] m [32];
  logic [31:0] e_rd1, e_rd2;
  logic        e_val;
  int          busy_left;

  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .tap_0(tap_0), .tap_1(tap_1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = '0;
    e_rd1 = '0; e_rd2 = '0; e_val = 1'b0; busy_left = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 0) ? 32'h0 : m[a];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a && a != 0) v = wr_data;
`endif
    return v;
  endfunction

  task automatic idle_inputs();
    rd_en = 0; wr_en = 0; clr_req = 0;
  endtask

  // One clock: advance the reference model from the current inputs, then compare all outputs.
  task automatic tick();
    if (busy_left == 0) begin
      if (rd_en) begin
        e_rd1 = model_read(rd_addr_1);
        e_rd2 = model_read(rd_addr_2);
      end
      e_val = rd_en;
      if (wr_en && wr_addr != 0) m[wr_addr] = wr_data;
      if (clr_req) busy_left = 32;
    end else begin
      e_val = 1'b0;
      m[32 - busy_left] = '0;
      busy_left--;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", {31'b0, rd_valid}, {31'b0, e_val});
    chk("rd_data_1", rd_data_1, e_rd1);
    chk("rd_data_2", rd_data_2, e_rd2);
    chk("clr_busy", {31'b0, clr_busy}, {31'b0, busy_left != 0});
    chk("tap_0", tap_0, m[2]);
    chk("tap_1", tap_1, m[4]);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst rd_data_1", rd_data_1, 32'h0);
    chk("rst rd_data_2", rd_data_2, 32'h0);
    chk("rst rd_valid", {31'b0, rd_valid}, 32'h0);
    chk("rst clr_busy", {31'b0, clr_busy}, 32'h0);
    chk("rst tap_0", tap_0, 32'h0);
    model_reset();
    #2 rst = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle_inputs(); wr_en = 1; wr_addr = a; wr_data = d; tick();
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    idle_inputs(); rd_en = 1; rd_addr_1 = a1; rd_addr_2 = a2; tick();
  endtask

  typedef struct {
    logic rd_en; logic [4:0] a1, a2; logic wr_en; logic [4:0] wa; logic [31:0] wd;
    logic e_val; logic [31:0] e_rd1, e_rd2, e_tap0, e_tap1;
  } vec_t;
  vec_t vt [10];

  int busy_cnt;

  initial begin
    logic [31:0] same_edge;
`ifdef REGFILE_BYPASS_EN
    same_edge = 32'h2;
`else
    same_edge = 32'h1;
`endif
    vt[0] = '{0, 0, 0, 1, 3, 32'h12345678, 0, 0, 0, 0, 0};
    vt[1] = '{1, 3, 0, 0, 0, 0, 1, 32'h12345678, 0, 0, 0};
    vt[2] = '{0, 0, 0, 0, 0, 0, 0, 32'h12345678, 0, 0, 0};
    vt[3] = '{0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 32'h12345678, 0, 0, 0};
    vt[4] = '{1, 0, 3, 0, 0, 0, 1, 0, 32'h12345678, 0, 0};
    vt[5] = '{0, 0, 0, 1, 2, 7, 0, 0, 32'h12345678, 7, 0};
    vt[6] = '{0, 0, 0, 1, 4, 9, 0, 0, 32'h12345678, 7, 9};
    vt[7] = '{0, 0, 0, 1, 8, 1, 0, 0, 32'h12345678, 7, 9};
    vt[8] = '{1, 8, 2, 1, 8, 2, 1, same_edge, 7, 7, 9};
    vt[9] = '{1, 8, 4, 0, 0, 0, 1, 2, 9, 7, 9};

    model_reset();
    @(posedge clk); #1;
    chk("reset rd_valid", {31'b0, rd_valid}, 32'h0);
    chk("reset clr_busy", {31'b0, clr_busy}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      rd_en = vt[i].rd_en; rd_addr_1 = vt[i].a1; rd_addr_2 = vt[i].a2;
      wr_en = vt[i].wr_en; wr_addr = vt[i].wa; wr_data = vt[i].wd; clr_req = 0;
      tick();
      chk($sformatf("vec%0d rd_valid", i), {31'b0, rd_valid}, {31'b0, vt[i].e_val});
      chk($sformatf("vec%0d rd_data_1", i), rd_data_1, vt[i].e_rd1);
      chk($sformatf("vec%0d rd_data_2", i), rd_data_2, vt[i].e_rd2);
      chk($sformatf("vec%0d tap_0", i), tap_0, vt[i].e_tap0);
      chk($sformatf("vec%0d tap_1", i), tap_1, vt[i].e_tap1);
    end

    // Async reset mid-cycle wipes array and read registers.
    wr(5, 32'hDEADBEEF);
    rd(5, 2);
    async_reset();
    rd(5, 2);
    chk("post-reset reg5", rd_data_1, 32'h0);

    // Bulk clear with writes/reads attempted while busy.
    for (int i = 1; i < 32; i++) wr(i[4:0], i);
    idle_inputs(); clr_req = 1; tick();
    busy_cnt = 0;
    for (int i = 0; i < 40 && clr_busy; i++) begin
      clr_req = 0; rd_en = 1; wr_en = 1;
      wr_addr = 5'($urandom_range(1, 31)); wr_data = $urandom;
      rd_addr_1 = 5'($urandom); rd_addr_2 = 5'($urandom);
      busy_cnt++;
      tick();
    end
    chk("clear busy cycles", busy_cnt, 32);
    for (int i = 0; i < 32; i += 2) begin
      rd(i[4:0], 5'(i + 1));
      chk("cleared rd1", rd_data_1, 32'h0);
      chk("cleared rd2", rd_data_2, 32'h0);
    end

    // Write+read+clear on one edge, then a re-request during busy.
    idle_inputs(); clr_req = 1; wr_en = 1; wr_addr = 9; wr_data = 32'hAA;
    rd_en = 1; rd_addr_1 = 9; rd_addr_2 = 2; tick();
    busy_cnt = 0;
    for (int i = 0; i < 40 && clr_busy; i++) begin
      idle_inputs(); clr_req = (i == 3 || i == 30);
      busy_cnt++;
      tick();
    end
    chk("overlap busy cycles", busy_cnt, 32);
    rd(9, 0);
    chk("reg9 after clear", rd_data_1, 32'h0);

    // Reset aborts a running clear.
    wr(2, 32'h55);
    idle_inputs(); clr_req = 1; tick();
    clr_req = 0;
    for (int i = 0; i < 10; i++) tick();
    async_reset();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rd_en = 1'($urandom); wr_en = 1'($urandom);
      rd_addr_1 = 5'($urandom_range(0, 9)); rd_addr_2 = 5'($urandom_range(0, 9));
      wr_addr = 5'($urandom_range(0, 9)); wr_data = $urandom;
      clr_req = ($urandom_range(0, 59) == 0);
      tick();
    end

    idle_inputs();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
